// File: rtl/if_fetch_pkg.sv
// Shared widths and types for the instruction fetch unit: instruction bus,
// PC, memory word and byte-queue depth.
package if_fetch_pkg;
    localparam int INSTBUS       = 48;
    localparam int PCLEN         = 32;
    localparam int IMEM_WORD     = 32;
    localparam int FETCH_Q_BYTES = 12;
    localparam int WORD_BYTES    = IMEM_WORD / 8;
    localparam int INST_BYTES    = INSTBUS / 8;

    typedef logic [INSTBUS-1:0]   inst_t;
    typedef logic [PCLEN-1:0]     pc_t;
    typedef logic [IMEM_WORD-1:0] word_t;

    function automatic pc_t word_align(input pc_t a);
        return {a[PCLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_if.sv
// CPU-side request/instruction signals plus the instruction-memory read port.
// master = fetch unit, slave = CPU and memory environment.
interface if_fetch_if;
    import if_fetch_pkg::*;

    pc_t   cpu_pc_i;
    logic  cpu_req_i;
    inst_t cpu_inst_o;
    logic  cpu_valid_o;
    logic  imem_en_o;
    pc_t   imem_addr_o;
    word_t imem_data_i;

    modport master (
        input  cpu_pc_i, cpu_req_i, imem_data_i,
        output cpu_inst_o, cpu_valid_o, imem_en_o, imem_addr_o
    );

    modport slave (
        output cpu_pc_i, cpu_req_i, imem_data_i,
        input  cpu_inst_o, cpu_valid_o, imem_en_o, imem_addr_o
    );
endinterface

// File: rtl/fetch_byteq.sv
// 12-byte fetch queue, byte 0 = head. Each edge drops drop_i head bytes and
// appends one word at wr_pos_i (post-drop position); read extracts 6 bytes combinationally.
module fetch_byteq
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] drop_i,
    input  logic       wr_en_i,
    input  logic [3:0] wr_pos_i,
    input  word_t      wr_dat_i,
    input  logic [3:0] rd_off_i,
    output inst_t      rd_dat_o
);
    localparam int QW = FETCH_Q_BYTES * 8;
    localparam logic [QW-1:0] WMASK = {{(QW-IMEM_WORD){1'b0}}, {IMEM_WORD{1'b1}}};

    logic [QW-1:0]      mem_q, mem_d;
    logic [INSTBUS-1:0] rd_lo;

    always_comb begin
        mem_d = mem_q >> {drop_i, 3'b000};
        if (wr_en_i) begin
            mem_d = (mem_d & ~(WMASK << {wr_pos_i, 3'b000}))
                  | ({{(QW-IMEM_WORD){1'b0}}, wr_dat_i} << {wr_pos_i, 3'b000});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Queue is little-endian by address; the CPU wants the lowest address in the MSBs.
    assign rd_lo    = INSTBUS'(mem_q >> {rd_off_i, 3'b000});
    assign rd_dat_o = {rd_lo[7:0], rd_lo[15:8], rd_lo[23:16],
                       rd_lo[31:24], rd_lo[39:32], rd_lo[47:40]};
endmodule

// File: rtl/if_fetch.sv
// Instruction prefetcher: keeps a 12-byte window ahead of the CPU PC and serves 6-byte
// instructions combinationally; a miss flushes and refetches (3-4 cycle cold latency).
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);
    pc_t        q_addr_q, q_addr_d;
    logic [3:0] q_cnt_q, q_cnt_d;
    logic       inflight_q, inflight_d;
    pc_t        off, issue_addr;
    logic [4:0] fill_lvl;
    logic [3:0] drop;
    logic       hit, miss, append, issue;

    always_comb begin
        off      = bus.cpu_pc_i - q_addr_q;
        fill_lvl = {1'b0, q_cnt_q} + (inflight_q ? 5'(WORD_BYTES) : 5'd0);
        hit      = bus.cpu_req_i && (off <= {28'd0, q_cnt_q});
        miss     = bus.cpu_req_i && (off > {27'd0, fill_lvl});
        drop     = hit ? off[3:0] : 4'd0;
        append   = inflight_q && !miss;
        issue    = miss || (fill_lvl <= 5'(FETCH_Q_BYTES - WORD_BYTES));

        q_addr_d   = q_addr_q;
        q_cnt_d    = q_cnt_q;
        inflight_d = issue;
        issue_addr = q_addr_q + {27'd0, fill_lvl};

        // A miss also drops the word arriving this cycle: it belongs to the old stream.
        if (miss) begin
            q_addr_d   = word_align(bus.cpu_pc_i);
            q_cnt_d    = 4'd0;
            issue_addr = word_align(bus.cpu_pc_i);
        end else begin
            if (hit) begin
                q_addr_d = bus.cpu_pc_i;
            end
            q_cnt_d = q_cnt_q - drop + (append ? 4'(WORD_BYTES) : 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_addr_q   <= '0;
            q_cnt_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            q_addr_q   <= q_addr_d;
            q_cnt_q    <= q_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_byteq u_byteq (
        .clk      (clk),
        .rst      (rst),
        .drop_i   (drop),
        .wr_en_i  (append),
        .wr_pos_i (q_cnt_q - drop),
        .wr_dat_i (bus.imem_data_i),
        .rd_off_i (off[3:0]),
        .rd_dat_o (bus.cpu_inst_o)
    );

    assign bus.imem_en_o   = rst && issue;
    assign bus.imem_addr_o = rst ? issue_addr : '0;
    assign bus.cpu_valid_o = rst && hit
                          && (({1'b0, off[3:0]} + 5'(INST_BYTES)) <= {1'b0, q_cnt_q});
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory byte at address a is {a[3:0],a[3:0]} ^ a[11:4];
// expected instructions below are hand-derived from that pattern.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic mon_seq = 1'b0;
    pc_t  next_fetch = '0;

    if_fetch_if bus ();

    if_fetch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input pc_t a);
        return {a[3:0], a[3:0]} ^ a[11:4];
    endfunction

    function automatic word_t mem_word(input pc_t a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    function automatic inst_t exp_inst(input pc_t pc);
        inst_t r;
        r = '0;
        for (int j = 0; j < 6; j++) r = {r[39:0], mb(pc + 32'(j))};
        return r;
    endfunction

    // Read data appears exactly one cycle after the request; garbage otherwise.
    always @(posedge clk)
        bus.imem_data_i <= bus.imem_en_o ? mem_word(bus.imem_addr_o) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q, input pc_t pc);
        @(posedge clk);
        #1;
        rst = r;
        bus.cpu_req_i = q;
        bus.cpu_pc_i  = pc;
        #1;
        if (mon_seq && bus.imem_en_o) begin
            chk("seq_fetch_addr", bus.imem_addr_o, next_fetch);
            next_fetch = next_fetch + 32'd4;
        end
    endtask

    task automatic stream_to(input pc_t pc);
        drive(1'b1, 1'b1, pc);
        for (int n = 0; n < 10 && bus.cpu_valid_o !== 1'b1; n++) drive(1'b1, 1'b1, pc);
        chk("stream_vld", bus.cpu_valid_o, 1'b1);
        chk("stream_inst", bus.cpu_inst_o, exp_inst(pc));
    endtask

    initial begin
        rst = 1'b0;
        bus.cpu_req_i = 1'b0;
        bus.cpu_pc_i  = '0;

        // Reset state
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        chk("rst_vld", bus.cpu_valid_o, 1'b0);
        chk("rst_en", bus.imem_en_o, 1'b0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);

        // Cold start from reset vector, pc=0 held
        drive(1'b1, 1'b1, 32'h0);
        chk("boot_en", bus.imem_en_o, 1'b1);
        chk("boot_addr0", bus.imem_addr_o, 32'h0);
        chk("boot_vld0", bus.cpu_valid_o, 1'b0);
        drive(1'b1, 1'b1, 32'h0);
        chk("boot_addr1", bus.imem_addr_o, 32'h4);
        drive(1'b1, 1'b1, 32'h0);
        chk("boot_addr2", bus.imem_addr_o, 32'h8);
        chk("boot_vld2", bus.cpu_valid_o, 1'b0);
        drive(1'b1, 1'b1, 32'h0);
        chk("boot_vld3", bus.cpu_valid_o, 1'b1);
        chk("boot_inst", bus.cpu_inst_o, 48'h0011_2233_4455);
        chk("boot_full_en", bus.imem_en_o, 1'b0);

        // Sequential stream: fetches must continue 12,16,20... with no refetch
        mon_seq    = 1'b1;
        next_fetch = 32'd12;
        stream_to(32'd2);
        stream_to(32'd8);
        stream_to(32'd14);
        chk("s14_inst", bus.cpu_inst_o, 48'hEEFF_0110_2332);
        drive(1'b1, 1'b0, 32'd14);
        chk("s_idle_en", bus.imem_en_o, 1'b1);
        mon_seq = 1'b0;

        // Jump with a word in flight
        drive(1'b1, 1'b1, 32'h103);
        chk("jmp_en", bus.imem_en_o, 1'b1);
        chk("jmp_addr", bus.imem_addr_o, 32'h100);
        chk("jmp_vld0", bus.cpu_valid_o, 1'b0);
        drive(1'b1, 1'b1, 32'h103);
        chk("jmp_addr1", bus.imem_addr_o, 32'h104);
        chk("jmp_vld1", bus.cpu_valid_o, 1'b0);
        drive(1'b1, 1'b1, 32'h103);
        chk("jmp_addr2", bus.imem_addr_o, 32'h108);
        chk("jmp_vld2", bus.cpu_valid_o, 1'b0);
        drive(1'b1, 1'b1, 32'h103);
        chk("jmp_vld3", bus.cpu_valid_o, 1'b0);
        drive(1'b1, 1'b1, 32'h103);
        chk("jmp_vld4", bus.cpu_valid_o, 1'b1);
        chk("jmp_inst", bus.cpu_inst_o, 48'h2354_4576_6798);

        // Stall after a flush: fills to 12 bytes, then stops requesting
        drive(1'b1, 1'b1, 32'h200);
        chk("stall_miss_addr", bus.imem_addr_o, 32'h200);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 32'h200);
            chk("stall_en", bus.imem_en_o, i < 2);
            if (i < 2) chk("stall_addr", bus.imem_addr_o, 32'h204 + 32'(4 * i));
        end
        drive(1'b1, 1'b1, 32'h206);
        chk("resume_vld", bus.cpu_valid_o, 1'b1);
        chk("resume_inst", bus.cpu_inst_o, 48'h4657_A8B9_8A9B);
        chk("resume_en", bus.imem_en_o, 1'b0);
        drive(1'b1, 1'b0, 32'h206);
        chk("resume_fill_addr", bus.imem_addr_o, 32'h20C);
        chk("resume_fill_en", bus.imem_en_o, 1'b1);

        // Reset while 0x20C is in flight
        drive(1'b0, 1'b0, 32'h0);
        chk("mrst_vld", bus.cpu_valid_o, 1'b0);
        chk("mrst_en", bus.imem_en_o, 1'b0);
        chk("mrst_addr", bus.imem_addr_o, 32'h0);
        drive(1'b1, 1'b1, 32'h0);
        chk("mrst_refetch_en", bus.imem_en_o, 1'b1);
        chk("mrst_refetch_addr", bus.imem_addr_o, 32'h0);
        drive(1'b1, 1'b1, 32'h0);
        chk("mrst_addr1", bus.imem_addr_o, 32'h4);
        drive(1'b1, 1'b1, 32'h0);
        drive(1'b1, 1'b1, 32'h0);
        chk("mrst_vld3", bus.cpu_valid_o, 1'b1);
        chk("mrst_inst", bus.cpu_inst_o, 48'h0011_2233_4455);

        // Address wrap
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr1", bus.imem_addr_o, 32'h0000_0000);
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr2", bus.imem_addr_o, 32'h0000_0004);
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_vld", bus.cpu_valid_o, 1'b1);
        chk("wrap_inst", bus.cpu_inst_o, 48'h3322_1100_0011);
        drive(1'b1, 1'b1, 32'hFFFF_FFFE);
        chk("wrap2_vld", bus.cpu_valid_o, 1'b1);
        chk("wrap2_inst", bus.cpu_inst_o, 48'h1100_0011_2233);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low (rst==0 resets on clk rising edge).
REQ-003 cpu_pc_i  input  32  byte address of instruction the CPU wants this cycle.
REQ-004 cpu_req_i  input  1  cpu_pc_i is valid this cycle.
REQ-005 cpu_inst_o  output  48  bytes pc..pc+5; byte at pc in [47:40], pc+5 in [7:0].
REQ-006 cpu_valid_o  output  1  cpu_inst_o holds all 6 bytes for cpu_pc_i this cycle.
REQ-007 imem_en_o  output  1  word read request to instruction memory.
REQ-008 imem_addr_o  output  32  word-aligned read address ([1:0]==0).
REQ-009 imem_data_i  input  32  read data, valid exactly 1 cycle after imem_en_o; byte addr+0 in [7:0].

Function
REQ-010 Block SHALL hold a byte queue of 12 bytes: head address q_addr, count q_cnt (0..12), plus at most one in-flight word flag.
REQ-011 Window SHALL be [q_addr, q_addr+q_cnt+(inflight?4:0)], 32-bit modular arithmetic throughout.
REQ-012 cpu_valid_o SHALL be combinational: cpu_req_i && cpu_pc_i>=q_addr && cpu_pc_i+6<=q_addr+q_cnt; cpu_inst_o is don't-care when cpu_valid_o==0.
REQ-013 Hit: if cpu_req_i and cpu_pc_i in [q_addr, q_addr+q_cnt], head SHALL advance to cpu_pc_i at the edge (drop cpu_pc_i-q_addr bytes).
REQ-014 Pending: if cpu_pc_i in (q_addr+q_cnt, window end], queue SHALL hold unchanged except fill.
REQ-015 Miss: if cpu_req_i and cpu_pc_i outside window, block SHALL flush: q_cnt<=0, q_addr<={cpu_pc_i[31:2],2'b00}, in-flight response discarded, and issue read of that aligned address in the same cycle.
REQ-016 Fill: read SHALL issue at address q_addr+q_cnt+(inflight?4:0) when q_cnt+(inflight?4:0)+4<=12 and no miss this cycle; back-to-back issue every cycle allowed.
REQ-017 Returned word SHALL append 4 bytes in the cycle it arrives, unless flushed that cycle.
REQ-018 Simultaneous hit-drop and word-append SHALL both apply in one edge: q_cnt_next = q_cnt - drop + 4.
REQ-019 Queue full (q_cnt+inflight bytes==12) SHALL suppress imem_en_o.
REQ-020 cpu_req_i==0 SHALL leave head unchanged; fill continues.
REQ-021 Cold latency after miss at cycle 0: cpu_valid_o SHALL assert in cycle 3 for cpu_pc_i[1:0]<=2, cycle 4 for [1:0]==3 (pc held constant).
REQ-022 Address wrap past 0xFFFFFFFC SHALL continue at 0x00000000.

Reset
REQ-023 On rst==0: q_addr=0, q_cnt=0, inflight=0, cpu_valid_o=0, imem_en_o=0, imem_addr_o=0.
REQ-024 Reset mid-operation SHALL discard any in-flight response arriving the cycle after reset.
REQ-025 First cycle after reset release SHALL issue fetch of address 0 (prefetch of reset vector).

Structure
REQ-026 Shared defines file SHALL hold INSTBUS (47:0), PCLEN (31:0), IMEM_WORD (31:0), FETCH_Q_BYTES (12).
REQ-027 Byte storage plus shift/extract logic SHALL be one sub-module, fetch_byteq; control/window logic stays in if_fetch.

Verification
REQ-028 Reset, then cpu_pc_i=0 held, memory word0=0x33221100, word1=0x77665544 -> cpu_valid_o=1 in cycle 3 after release, cpu_inst_o=0x001122334455.
REQ-029 Sequential stream pc 0,2,8,14 with valid each -> no flush, imem_en_o never addresses below q_addr, each cpu_inst_o matches memory.
REQ-030 Jump to pc=0x103 from steady state -> flush, imem_addr_o=0x100 same cycle, in-flight word dropped, cpu_valid_o=1 in cycle 4 with bytes 0x103..0x108.
REQ-031 CPU stalls (cpu_req_i=0) 20 cycles -> fills to q_cnt=12, imem_en_o deasserts, no overflow, correct data when req resumes.
REQ-032 rst pulled low with a read in flight -> next cycle state equals reset values, stale data ignored, refetch from 0.
REQ-033 pc=0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000, cpu_inst_o spans wrap correctly.
